// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment serial display transmitter.
package sseg_pkg;
    localparam int SSEG_FRAME_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2,
        LATCH = 2'd3
    } state_t;
endpackage

// File: rtl/sseg_p2s_if.sv
// Frame handshake between the segment-mapping stage (master) and the transmitter (slave).
interface sseg_p2s_if
    import sseg_pkg::*;
#(
    parameter int WIDTH = SSEG_FRAME_W
);
    logic             start;
    logic [WIDTH-1:0] par_data;
    logic             ready;
    logic             done;

    modport master (output start, output par_data, input ready, input done);
    modport slave  (input start, input par_data, output ready, output done);
endinterface

// File: rtl/sseg_tick.sv
// Clock-enable counter: tick_end marks the last clk cycle of each DIV-cycle s_clk phase.
module sseg_tick
    import sseg_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick_end
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick_end ? '0 : cnt + CW'(1);
        end
    end

    assign tick_end = (cnt == CW'(DIV - 1));
endmodule

// File: rtl/sseg_p2s.sv
// Parallel-to-serial transmitter for the daisy-chained shift-register display:
// shifts a frame out MSB-first on a divided s_clk, then pulses the latch strobe.
module sseg_p2s
    import sseg_pkg::*;
#(
    parameter int WIDTH = SSEG_FRAME_W,
    parameter int DIV   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    sseg_p2s_if.slave  bus,
    output logic       s_clk,
    output logic       s_data,
    output logic       s_ld,
    output logic       s_clr_n
);
    localparam int BW = $clog2(WIDTH);

    state_t           state, nxt_state;
    logic [WIDTH-1:0] shreg, nxt_shreg;
    logic [BW-1:0]    bitcnt, nxt_bitcnt;
    logic             ready_r, done_r;
    logic             nxt_ready, nxt_done, nxt_s_clk, nxt_s_data, nxt_s_ld;
    logic             accept, tick_end;

    sseg_tick #(.DIV(DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .en       (state != IDLE),
        .tick_end (tick_end)
    );

    // Next values are computed for every output so that all pins leave a flop.
    always_comb begin
        nxt_state  = state;
        nxt_shreg  = shreg;
        nxt_bitcnt = bitcnt;
        nxt_ready  = ready_r;
        nxt_done   = 1'b0;
        nxt_s_clk  = s_clk;
        nxt_s_data = s_data;
        nxt_s_ld   = s_ld;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                nxt_ready = 1'b1;
                if (ready_r && bus.start) begin
                    accept     = 1'b1;
                    nxt_state  = LO;
                    nxt_shreg  = bus.par_data;
                    nxt_bitcnt = BW'(WIDTH - 1);
                    nxt_ready  = 1'b0;
                    nxt_s_clk  = 1'b0;
                    nxt_s_data = bus.par_data[WIDTH-1];
                end
            end
            LO: begin
                if (tick_end) begin
                    nxt_state = HI;
                    nxt_s_clk = 1'b1;
                end
            end
            HI: begin
                if (tick_end) begin
                    nxt_s_clk = 1'b0;
                    if (bitcnt == '0) begin
                        nxt_state  = LATCH;
                        nxt_s_ld   = 1'b1;
                        nxt_s_data = 1'b0;
                    end else begin
                        // Next bit appears on the falling edge, giving a full LO phase of setup.
                        nxt_state  = LO;
                        nxt_shreg  = {shreg[WIDTH-2:0], 1'b0};
                        nxt_s_data = shreg[WIDTH-2];
                        nxt_bitcnt = bitcnt - BW'(1);
                    end
                end
            end
            LATCH: begin
                if (tick_end) begin
                    nxt_state = IDLE;
                    nxt_s_ld  = 1'b0;
                    nxt_done  = 1'b1;
                    nxt_ready = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            s_clk   <= 1'b0;
            s_data  <= 1'b0;
            s_ld    <= 1'b0;
            s_clr_n <= 1'b0;
        end else begin
            state   <= nxt_state;
            shreg   <= nxt_shreg;
            bitcnt  <= nxt_bitcnt;
            ready_r <= nxt_ready;
            done_r  <= nxt_done;
            s_clk   <= nxt_s_clk;
            s_data  <= nxt_s_data;
            s_ld    <= nxt_s_ld;
            s_clr_n <= 1'b1;
        end
    end

    assign bus.ready = ready_r;
    assign bus.done  = done_r;
endmodule
